// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by both the receive demux and the transmit-side sequencer.
package tdm_pkg;

    localparam int unsigned TDM_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SLOT0 = 2'd1,
        ST_SLOT1 = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_shift_in.sv
// MSB-first serial-to-parallel shift register with enable and synchronous clear.
// q_nxt_c presents the word including the bit currently on din, so a word is complete on its last beat.
module tdm_shift_in #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q_nxt_c
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Oldest stored bit falls off the top as din enters at the bottom.
    assign q_nxt_c = WIDTH'({shreg_q, din});

    always_comb begin
        shreg_d = shreg_q;
        if (clr) begin
            shreg_d = '0;
        end else if (en) begin
            shreg_d = q_nxt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM receiver: locks to fsync, deserializes slot 0 to channel A and slot 1 to channel C.
module tdm_demux_2ch
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = TDM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             sdata,
    input  logic             fsync,
    output logic [WIDTH-1:0] ch_a_data,
    output logic             ch_a_vld,
    output logic [WIDTH-1:0] ch_c_data,
    output logic             ch_c_vld,
    output logic             locked,
    output logic             frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tdm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_sync_q, exp_sync_d;
    logic [WIDTH-1:0] ch_a_data_q, ch_a_data_d;
    logic [WIDTH-1:0] ch_c_data_q, ch_c_data_d;
    logic             ch_a_vld_q, ch_a_vld_d;
    logic             ch_c_vld_q, ch_c_vld_d;
    logic             locked_q, locked_d;
    logic             frame_err_q, frame_err_d;
    logic             sh_en, sh_clr;
    logic [WIDTH-1:0] word_c;

    tdm_shift_in #(.WIDTH(WIDTH)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sh_en),
        .clr     (sh_clr),
        .din     (sdata),
        .q_nxt_c (word_c)
    );

    // Next-state, counter and output decode; everything advances only on beats.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_sync_d  = exp_sync_q;
        ch_a_data_d = ch_a_data_q;
        ch_c_data_d = ch_c_data_q;
        ch_a_vld_d  = 1'b0;
        ch_c_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        sh_en       = 1'b0;
        sh_clr      = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (fsync) begin
                        sh_en      = 1'b1;
                        cnt_d      = CNT_ONE;
                        exp_sync_d = 1'b0;
                        state_d    = ST_SLOT0;
                    end
                end
                ST_SLOT0: begin
                    if (exp_sync_q) begin
                        // First beat after a completed frame must carry the next sync.
                        exp_sync_d = 1'b0;
                        if (fsync) begin
                            sh_en = 1'b1;
                            cnt_d = CNT_ONE;
                        end else begin
                            sh_clr      = 1'b1;
                            cnt_d       = '0;
                            frame_err_d = 1'b1;
                            state_d     = ST_HUNT;
                        end
                    end else if (fsync) begin
                        sh_en       = 1'b1;
                        cnt_d       = CNT_ONE;
                        frame_err_d = 1'b1;
                    end else begin
                        sh_en = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            ch_a_data_d = word_c;
                            ch_a_vld_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = ST_SLOT1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_SLOT1: begin
                    sh_en = 1'b1;
                    if (fsync) begin
                        cnt_d       = CNT_ONE;
                        frame_err_d = 1'b1;
                        state_d     = ST_SLOT0;
                    end else if (cnt_q == CNT_LAST) begin
                        ch_c_data_d = word_c;
                        ch_c_vld_d  = 1'b1;
                        cnt_d       = '0;
                        exp_sync_d  = 1'b1;
                        state_d     = ST_SLOT0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    sh_clr  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HUNT;
                end
            endcase
        end

        locked_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            cnt_q       <= '0;
            exp_sync_q  <= 1'b0;
            ch_a_data_q <= '0;
            ch_c_data_q <= '0;
            ch_a_vld_q  <= 1'b0;
            ch_c_vld_q  <= 1'b0;
            locked_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_sync_q  <= exp_sync_d;
            ch_a_data_q <= ch_a_data_d;
            ch_c_data_q <= ch_c_data_d;
            ch_a_vld_q  <= ch_a_vld_d;
            ch_c_vld_q  <= ch_c_vld_d;
            locked_q    <= locked_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ch_a_data = ch_a_data_q;
    assign ch_c_data = ch_c_data_q;
    assign ch_a_vld  = ch_a_vld_q;
    assign ch_c_vld  = ch_c_vld_q;
    assign locked    = locked_q;
    assign frame_err = frame_err_q;

endmodule
